// File: rtl/ar_order_router_if.sv
// AR channel bundle for ar_order_router: master AR payload/handshake, shared
// slave AR payload with per-slave handshakes, and the monitored R handshake.
interface ar_order_router_if #(
    parameter int unsigned ADDR_width = 32,
    parameter int unsigned ID_width   = 6,
    parameter int unsigned mID_width  = 2,
    parameter int unsigned user_width = 6
);
    logic [mID_width-1:0]  m_ARID;
    logic [ADDR_width-1:0] m_ARADDR;
    logic [7:0]            m_ARLEN;
    logic [2:0]            m_ARSIZE;
    logic [1:0]            m_ARBURST;
    logic [user_width-1:0] m_ARUSER;
    logic                  m_ARVALID;
    logic                  m_ARREADY;

    logic [ID_width-1:0]   s_ARID;
    logic [ADDR_width-1:0] s_ARADDR;
    logic [7:0]            s_ARLEN;
    logic [2:0]            s_ARSIZE;
    logic [1:0]            s_ARBURST;
    logic [user_width-1:0] s_ARUSER;
    logic s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID, s4_ARVALID;
    logic s0_ARREADY, s1_ARREADY, s2_ARREADY, s3_ARREADY, s4_ARREADY;

    logic                  m_RVALID;
    logic                  m_RREADY;
    logic                  m_RLAST;
    logic [2:0]            R_SLV_sel;
    logic                  R_hold;

    // Router side
    modport slave (
        input  m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARUSER, m_ARVALID,
        output m_ARREADY,
        output s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARUSER,
        output s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID, s4_ARVALID,
        input  s0_ARREADY, s1_ARREADY, s2_ARREADY, s3_ARREADY, s4_ARREADY,
        input  m_RVALID, m_RREADY, m_RLAST,
        output R_SLV_sel, R_hold
    );

    // Environment side
    modport master (
        output m_ARID, m_ARADDR, m_ARLEN, m_ARSIZE, m_ARBURST, m_ARUSER, m_ARVALID,
        input  m_ARREADY,
        input  s_ARID, s_ARADDR, s_ARLEN, s_ARSIZE, s_ARBURST, s_ARUSER,
        input  s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID, s4_ARVALID,
        output s0_ARREADY, s1_ARREADY, s2_ARREADY, s3_ARREADY, s4_ARREADY,
        output m_RVALID, m_RREADY, m_RLAST,
        input  R_SLV_sel, R_hold
    );
endinterface

// File: rtl/ar_order_router.sv
// Read-address router: decodes ARADDR[31:20] to one of five slaves, issues one
// request at a time, and keeps a 4-deep FIFO of slave indices so the R path
// knows which slave returns the next burst.
module ar_order_router #(
    parameter int unsigned ADDR_width = 32,
    parameter int unsigned ID_width   = 6,
    parameter int unsigned mID_width  = 2,
    parameter int unsigned user_width = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    ar_order_router_if.slave   bus
);
    localparam int unsigned NSLV       = 5;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                 state_q, state_d;
    logic                   arready_q, arready_d;
    logic [NSLV-1:0]        valid_q, valid_d;
    logic [ID_width-1:0]    id_q, id_d;
    logic [ADDR_width-1:0]  addr_q, addr_d;
    logic [7:0]             len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [user_width-1:0]  user_q, user_d;
    logic [SEL_W-1:0]       mem_q [FIFO_DEPTH];
    logic [SEL_W-1:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0]       rsel_q, rsel_d;
    logic                   rhold_q, rhold_d;

    logic [SEL_W-1:0]       dec_slv_c;
    logic [NSLV-1:0]        slv_ready_c;
    logic                   accept_c, issued_c, pop_c;

    // Address region decode; anything outside the first five 1 MiB regions goes to slave 4
    always_comb begin
        dec_slv_c = SEL_W'(4);
        case (bus.m_ARADDR[31:20])
            12'h000: dec_slv_c = SEL_W'(0);
            12'h001: dec_slv_c = SEL_W'(1);
            12'h002: dec_slv_c = SEL_W'(2);
            12'h003: dec_slv_c = SEL_W'(3);
            default: dec_slv_c = SEL_W'(4);
        endcase
    end

    assign slv_ready_c = {bus.s4_ARREADY, bus.s3_ARREADY, bus.s2_ARREADY,
                          bus.s1_ARREADY, bus.s0_ARREADY};
    assign accept_c    = bus.m_ARVALID && arready_q;
    assign issued_c    = |(valid_q & slv_ready_c);
    assign pop_c       = bus.m_RVALID && bus.m_RREADY && bus.m_RLAST && (cnt_q != '0);

    // Next-state: issue FSM, payload capture, order FIFO and registered outputs
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        user_d  = user_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = ISSUE;
                    valid_d = NSLV'(1) << dec_slv_c;
                    id_d    = ID_width'(bus.m_ARID);
                    addr_d  = bus.m_ARADDR;
                    len_d   = bus.m_ARLEN;
                    size_d  = bus.m_ARSIZE;
                    burst_d = bus.m_ARBURST;
                    user_d  = bus.m_ARUSER;
                end
            end
            ISSUE: begin
                if (issued_c) begin
                    state_d = IDLE;
                    valid_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = '0;
            end
        endcase

        // A pop on the same edge as a push frees the slot; a pop on empty never reaches here
        if (accept_c) begin
            mem_d[wptr_q] = dec_slv_c;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({accept_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        arready_d = (state_d == IDLE) && (cnt_d < CNT_W'(FIFO_DEPTH));
        rhold_d   = (cnt_d == '0);
        rsel_d    = (cnt_d == '0) ? SEL_NONE : mem_d[rptr_d];
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            valid_q   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            user_q    <= '0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rsel_q    <= SEL_NONE;
            rhold_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            user_q    <= user_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            rsel_q    <= rsel_d;
            rhold_q   <= rhold_d;
        end
    end

    assign bus.m_ARREADY  = arready_q;
    assign bus.s_ARID     = id_q;
    assign bus.s_ARADDR   = addr_q;
    assign bus.s_ARLEN    = len_q;
    assign bus.s_ARSIZE   = size_q;
    assign bus.s_ARBURST  = burst_q;
    assign bus.s_ARUSER   = user_q;
    assign bus.s0_ARVALID = valid_q[0];
    assign bus.s1_ARVALID = valid_q[1];
    assign bus.s2_ARVALID = valid_q[2];
    assign bus.s3_ARVALID = valid_q[3];
    assign bus.s4_ARVALID = valid_q[4];
    assign bus.R_SLV_sel  = rsel_q;
    assign bus.R_hold     = rhold_q;
endmodule

// File: tb/tb_ar_order_router.sv
// Bench for ar_order_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ar_order_router;
    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    ar_order_router_if bus ();

    ar_order_router dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [4:0] valid_v;
    logic [4:0] ready_v;
    assign valid_v = {bus.s4_ARVALID, bus.s3_ARVALID, bus.s2_ARVALID, bus.s1_ARVALID, bus.s0_ARVALID};
    assign ready_v = {bus.s4_ARREADY, bus.s3_ARREADY, bus.s2_ARREADY, bus.s1_ARREADY, bus.s0_ARREADY};

    // Reference model: outstanding slave order, pending request and its payload
    int          q[$];
    bit          pend      = 1'b0;
    int          pend_slv  = 0;
    bit          exp_ready = 1'b0;
    logic [31:0] e_addr    = '0;
    logic [5:0]  e_id      = '0;
    logic [7:0]  e_len     = '0;
    logic [2:0]  e_size    = '0;
    logic [1:0]  e_burst   = '0;
    logic [5:0]  e_user    = '0;

    function automatic int region(input logic [31:0] a);
        int h;
        h = int'(a >> 20);
        return (h > 4) ? 4 : h;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            pend      = 1'b0;
            exp_ready = 1'b0;
            e_addr = '0; e_id = '0; e_len = '0; e_size = '0; e_burst = '0; e_user = '0;
        end else begin
            bit acc, hs, pop;
            acc = bus.m_ARVALID && exp_ready;
            hs  = pend && ready_v[pend_slv];
            pop = bus.m_RVALID && bus.m_RREADY && bus.m_RLAST && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (acc) begin
                pend_slv = region(bus.m_ARADDR);
                q.push_back(pend_slv);
                pend    = 1'b1;
                e_addr  = bus.m_ARADDR;
                e_id    = {4'b0000, bus.m_ARID};
                e_len   = bus.m_ARLEN;
                e_size  = bus.m_ARSIZE;
                e_burst = bus.m_ARBURST;
                e_user  = bus.m_ARUSER;
            end else if (hs) begin
                pend = 1'b0;
            end
            exp_ready = !pend && (q.size() < 4);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [4:0] ev;
        ev = pend ? (5'b00001 << pend_slv) : 5'b00000;
        chk("m_ARREADY", bus.m_ARREADY, exp_ready);
        chk("sN_ARVALID", valid_v, ev);
        chk("s_ARADDR", bus.s_ARADDR, e_addr);
        chk("s_ARID", bus.s_ARID, e_id);
        chk("s_AR len/size/burst/user", {bus.s_ARLEN, bus.s_ARSIZE, bus.s_ARBURST, bus.s_ARUSER},
            {e_len, e_size, e_burst, e_user});
        chk("R_SLV_sel", bus.R_SLV_sel, (q.size() != 0) ? q[0] : 7);
        chk("R_hold", bus.R_hold, q.size() == 0);
    end

    task automatic set_sready(input logic v);
        bus.s0_ARREADY = v; bus.s1_ARREADY = v; bus.s2_ARREADY = v;
        bus.s3_ARREADY = v; bus.s4_ARREADY = v;
    endtask

    // Present a request at a falling edge and return on the falling edge after acceptance
    task automatic accept(input logic [31:0] a, input logic [1:0] id, input logic [7:0] len);
        int n = 0;
        bus.m_ARVALID = 1'b1;
        bus.m_ARADDR  = a;
        bus.m_ARID    = id;
        bus.m_ARLEN   = len;
        bus.m_ARSIZE  = 3'd2;
        bus.m_ARBURST = 2'b01;
        bus.m_ARUSER  = len[5:0] ^ 6'h2a;
        while (!bus.m_ARREADY && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept wait", bus.m_ARREADY, 1'b1);
        @(negedge clk);
        bus.m_ARVALID = 1'b0;
    endtask

    task automatic slave_ready(input int d);
        repeat (d) @(negedge clk);
        set_sready(1'b1);
        @(negedge clk);
        set_sready(1'b0);
    endtask

    task automatic rlast_pulse();
        bus.m_RVALID = 1'b1; bus.m_RREADY = 1'b1; bus.m_RLAST = 1'b1;
        @(negedge clk);
        bus.m_RVALID = 1'b0; bus.m_RREADY = 1'b0; bus.m_RLAST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_ARVALID = 1'b0; bus.m_ARADDR = '0; bus.m_ARID = '0; bus.m_ARLEN = '0;
        bus.m_ARSIZE = '0; bus.m_ARBURST = '0; bus.m_ARUSER = '0;
        bus.m_RVALID = 1'b0; bus.m_RREADY = 1'b0; bus.m_RLAST = 1'b0;
        set_sready(1'b0);
        #1 reset_n = 1'b0;

        // Reset values, then first edge after release
        @(negedge clk);
        chk("rst m_ARREADY", bus.m_ARREADY, 1'b0);
        chk("rst sN_ARVALID", valid_v, 5'b00000);
        chk("rst s_ARADDR", bus.s_ARADDR, 32'h0);
        chk("rst R_SLV_sel", bus.R_SLV_sel, 3'b111);
        chk("rst R_hold", bus.R_hold, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("release m_ARREADY", bus.m_ARREADY, 1'b1);

        // Single read to slave 1 with two stall cycles
        @(negedge clk);
        accept(32'h0010_0040, 2'b10, 8'd3);
        chk("t1 valid c1", valid_v, 5'b00010);
        chk("t1 s_ARID", bus.s_ARID, 6'b000010);
        chk("t1 s_ARLEN", bus.s_ARLEN, 8'd3);
        chk("t1 m_ARREADY c1", bus.m_ARREADY, 1'b0);
        chk("t1 R_SLV_sel", bus.R_SLV_sel, 3'b001);
        chk("t1 R_hold", bus.R_hold, 1'b0);
        @(negedge clk);
        chk("t1 valid c2", valid_v, 5'b00010);
        chk("t1 m_ARREADY c2", bus.m_ARREADY, 1'b0);
        @(negedge clk);
        chk("t1 valid c3", valid_v, 5'b00010);
        bus.s1_ARREADY = 1'b1;
        @(negedge clk);
        bus.s1_ARREADY = 1'b0;
        chk("t1 valid dropped", valid_v, 5'b00000);
        chk("t1 m_ARREADY back", bus.m_ARREADY, 1'b1);
        rlast_pulse();
        chk("t1 R_hold after rlast", bus.R_hold, 1'b1);
        chk("t1 R_SLV_sel after rlast", bus.R_SLV_sel, 3'b111);

        // RLAST with empty FIFO is ignored
        rlast_pulse();
        chk("empty rlast R_hold", bus.R_hold, 1'b1);

        // Unmapped region goes to slave 4
        accept(32'h0090_0000, 2'b01, 8'd0);
        chk("unmapped valid", valid_v, 5'b10000);
        chk("unmapped R_SLV_sel", bus.R_SLV_sel, 3'b100);
        slave_ready(0);
        rlast_pulse();
        chk("unmapped drained", bus.R_hold, 1'b1);

        // Fill the FIFO: s0, s2, s3, s1
        accept(32'h0000_0100, 2'b00, 8'd1); slave_ready(0);
        accept(32'h0020_0200, 2'b01, 8'd2); slave_ready(0);
        accept(32'h0030_0300, 2'b10, 8'd4); slave_ready(0);
        accept(32'h0010_0400, 2'b11, 8'd7); slave_ready(0);
        chk("full R_SLV_sel", bus.R_SLV_sel, 3'b000);
        bus.m_ARVALID = 1'b1; bus.m_ARADDR = 32'h0040_0000; bus.m_ARID = 2'b01; bus.m_ARLEN = 8'd9;
        bus.m_ARUSER = 6'h05;
        chk("full m_ARREADY", bus.m_ARREADY, 1'b0);
        @(negedge clk);
        chk("full m_ARREADY held", bus.m_ARREADY, 1'b0);
        rlast_pulse();
        chk("full pop m_ARREADY", bus.m_ARREADY, 1'b1);
        chk("full pop R_SLV_sel", bus.R_SLV_sel, 3'b010);
        @(negedge clk);
        bus.m_ARVALID = 1'b0;
        chk("fifth valid", valid_v, 5'b10000);
        slave_ready(0);
        rlast_pulse();
        chk("seq R_SLV_sel 3", bus.R_SLV_sel, 3'b011);
        rlast_pulse();
        chk("seq R_SLV_sel 1", bus.R_SLV_sel, 3'b001);
        rlast_pulse();
        chk("seq R_SLV_sel 4", bus.R_SLV_sel, 3'b100);
        rlast_pulse();
        chk("seq R_hold", bus.R_hold, 1'b1);

        // Back-to-back requests with immediate slave ready
        for (int i = 0; i < 3; i++) begin
            accept(32'(i) << 20, 2'(i), 8'(i + 1));
            slave_ready(0);
        end
        repeat (3) rlast_pulse();

        // Push and pop on the same edge at count 1
        accept(32'h0000_0800, 2'b00, 8'd2);
        slave_ready(0);
        chk("simul head", bus.R_SLV_sel, 3'b000);
        chk("simul m_ARREADY", bus.m_ARREADY, 1'b1);
        bus.m_ARVALID = 1'b1; bus.m_ARADDR = 32'h0020_0010; bus.m_ARID = 2'b11;
        bus.m_RVALID = 1'b1; bus.m_RREADY = 1'b1; bus.m_RLAST = 1'b1;
        @(negedge clk);
        bus.m_ARVALID = 1'b0;
        bus.m_RVALID = 1'b0; bus.m_RREADY = 1'b0; bus.m_RLAST = 1'b0;
        chk("simul R_SLV_sel", bus.R_SLV_sel, 3'b010);
        chk("simul R_hold", bus.R_hold, 1'b0);
        slave_ready(0);
        rlast_pulse();
        chk("simul count was 1", bus.R_hold, 1'b1);

        // Reset while issuing to slave 3 with two entries queued
        accept(32'h0000_0000, 2'b00, 8'd0);
        slave_ready(0);
        accept(32'h0030_0000, 2'b01, 8'd0);
        chk("mid valid s3", valid_v, 5'b01000);
        #1 reset_n = 1'b0;
        #1;
        chk("mid rst valid", valid_v, 5'b00000);
        chk("mid rst R_hold", bus.R_hold, 1'b1);
        chk("mid rst R_SLV_sel", bus.R_SLV_sel, 3'b111);
        chk("mid rst m_ARREADY", bus.m_ARREADY, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid release m_ARREADY", bus.m_ARREADY, 1'b1);

        // Recovery transaction
        @(negedge clk);
        accept(32'h0020_0000, 2'b10, 8'd5);
        slave_ready(1);
        chk("recover R_SLV_sel", bus.R_SLV_sel, 3'b010);
        rlast_pulse();

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ar_order_router.md
AR_ORDER_ROUTER -- requirements
Module: ar_order_router

Interface
REQ-001 SHALL have parameter ADDR_width, default 32, read address width.
REQ-002 SHALL have parameter ID_width, default 6, slave-side ID width.
REQ-003 SHALL have parameter mID_width, default 2, master-side ID width.
REQ-004 SHALL have parameter user_width, default 6, AxUSER width.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports m_ARID/m_ARADDR/m_ARLEN/m_ARSIZE/m_ARBURST/m_ARUSER  in  mID_width/ADDR_width/8/3/2/user_width  master read-address payload.
REQ-008 SHALL have ports m_ARVALID  in  1 and m_ARREADY  out  1, the master AR handshake.
REQ-009 SHALL have ports s_ARID/s_ARADDR/s_ARLEN/s_ARSIZE/s_ARBURST/s_ARUSER  out  ID_width/ADDR_width/8/3/2/user_width  shared slave AR payload.
REQ-010 SHALL have ports s0..s4_ARVALID  out  1 each and s0..s4_ARREADY  in  1 each, the per-slave AR handshakes.
REQ-011 SHALL have ports m_RVALID, m_RREADY, m_RLAST  in  1 each, the master-side R handshake being monitored.
REQ-012 SHALL have ports R_SLV_sel  out  3 (read-data source slave) and R_hold  out  1 (block R path).

Function
REQ-013 SHALL decode ADDR[31:20] as follows: 0x000->slave0, 0x001->1, 0x002->2, 0x003->3, 0x004->4, any other value->slave4 (default slave).
REQ-014 SHALL implement FSM IDLE/ISSUE: IDLE->ISSUE on m_ARVALID&&m_ARREADY; ISSUE->IDLE on the selected sN_ARVALID&&sN_ARREADY.
REQ-015 SHALL drive m_ARREADY as a register that is 1 only when state is IDLE and the order FIFO holds fewer than 4 entries after this cycle's pop.
REQ-016 SHALL capture the payload into registers on acceptance, then drive s_AR* from those registers during ISSUE.
REQ-017 SHALL form s_ARID as m_ARID zero-extended to ID_width.
REQ-018 SHALL assert exactly one sN_ARVALID (the decoded slave) on the cycle after acceptance and hold it, with s_AR* stable, until sN_ARREADY is sampled high.
REQ-019 SHALL drive all sN_ARVALID to 0 in IDLE; s_AR* hold their last value in IDLE.
REQ-020 SHALL sustain a peak throughput of one request per 2 cycles; m_ARREADY returns high the cycle after the slave handshake, subject to REQ-015.
REQ-021 SHALL maintain a 4-entry order FIFO of 3-bit slave indices: push at acceptance, pop when m_RVALID&&m_RREADY&&m_RLAST is sampled high and the FIFO is non-empty.
REQ-022 SHALL use 2-bit read/write pointers that wrap 3->0, plus a 3-bit count in the range 0..4.
REQ-023 SHALL, on simultaneous push and pop, write and advance both pointers with the count unchanged; this SHALL hold at count 4 (pop frees the slot) and at count 0 (pop ignored; push only).
REQ-024 SHALL drive R_SLV_sel = head entry and R_HOLD = 0 when count>0; when count==0, SHALL drive R_SLV_sel = 3'b111 and R_hold = 1.
REQ-025 SHALL make R_SLV_sel/R_hold reflect a push one cycle after acceptance; a pop takes effect one cycle after the RLAST handshake.
REQ-026 SHALL ignore an RLAST handshake while the FIFO is empty, with no pointer or count change.
REQ-027 SHALL never push while the FIFO is full; m_ARREADY already prevents this.

Reset
REQ-028 SHALL, while reset_n is low and independent of clk, force: state IDLE, m_ARREADY 0, all sN_ARVALID 0, s_AR* 0, pointers and count 0, R_SLV_sel 3'b111, R_hold 1.
REQ-029 SHALL assert m_ARREADY 1 at the first rising edge after reset_n deasserts.
REQ-030 SHALL, on reset asserted mid-ISSUE or mid-burst, drop the pending request and flush all FIFO entries immediately.

Verification
REQ-031 SHALL cover reset: reset_n low -> outputs per REQ-028; first edge after release -> m_ARREADY=1.
REQ-032 SHALL cover single read: ARADDR=0x0010_0040, ARID=2'b10, ARLEN=3; s1_ARREADY low 2 cycles -> s1_ARVALID=1 held 3 cycles; s_ARID=6'b000010; m_ARREADY=0 throughout; then R_SLV_sel=3'b001, R_hold=0; after RLAST handshake -> R_hold=1, R_SLV_sel=3'b111.
REQ-033 SHALL cover unmapped address: ARADDR=0x0090_0000 -> s4_ARVALID=1, other ARVALIDs 0, R_SLV_sel=3'b100.
REQ-034 SHALL cover full FIFO: four reads to s0, s2, s3, s1 with no R traffic -> count=4, m_ARREADY=0 with a fifth request pending; one RLAST handshake -> m_ARREADY=1 next cycle; R_SLV_sel sequence 000, 010, 011, 001 across subsequent RLASTs.
REQ-035 SHALL cover simultaneous push and pop: count=1 (head s0), accepting s2 on the same edge as the s0 RLAST handshake -> count stays 1, R_SLV_sel=3'b010.
REQ-036 SHALL cover reset mid-ISSUE: reset_n low while s3_ARVALID=1 with 2 FIFO entries -> s3_ARVALID=0 and R_hold=1 before the next clk edge.
